// File: rtl/reaction_seq.sv
// reaction_seq -- sequencer for a single reaction-time trial.
//
// Holds the LED dim for a pseudo-random foreperiod (MIN_WAIT_MS plus a random
// 0..2^RAND_BITS-1 ms extension), switches it bright, then times the button
// response in ms. A press before the LED goes bright is a false start. No
// press within MAX_MS is a timeout.
//
// Optional feature: define BEST_TIME_EN to add best_ms. best_ms is the
// fastest valid (non-timeout) response since reset.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        single-cycle trial request; ignored while busy
//   btn          debounced button level, asynchronous to clk
//   bright       registered brightness select to the PWM dimmer (1 = bright)
//   busy         high while in WAIT or GO
//   result_ms    last response time in ms (MAX_MS on timeout), held
//   result_valid one-cycle pulse when result_ms is written
//   early        false-start flag, cleared by the next accepted start
//   timeout      no-response flag, cleared by the next accepted start
//   best_ms      (BEST_TIME_EN only) best valid response since reset
module reaction_seq #(
  parameter int TICK_DIV    = 50000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int MAX_MS      = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn,
  output logic        bright,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        early,
`ifdef BEST_TIME_EN
  output logic        timeout,
  output logic [13:0] best_ms
`else
  output logic        timeout
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_GO    = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_EARLY = 3'd4;

  localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0] MIN_W    = 14'(MIN_WAIT_MS);
  localparam logic [13:0] MAX_W    = 14'(MAX_MS);

  logic [2:0]    state;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic [13:0]   ms_cnt;
  logic [13:0]   target;

  // Button path: two synchronizer flops, a registered copy for edge detect,
  // and a registered rise pulse. This puts the state change three edges after
  // the first synchronizer flop captures the new level.
  logic btn_s1, btn_s2, btn_q, btn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_q    <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_q    <= btn_s2;
      btn_rise <= btn_s2 & ~btn_q;
    end
  end

  // Fibonacci LFSR with taps 16,14,13,11. It advances every cycle in every
  // state. As a result, the foreperiod depends on the exact cycle of the start
  // request. The non-zero seed keeps it out of the lock-up state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  logic        tick;
  logic [13:0] ms_nxt;
  logic [13:0] new_target;

  assign tick       = (presc == PRE_LAST);
  assign ms_nxt     = tick ? ms_cnt + 14'd1 : ms_cnt;
  assign new_target = MIN_W + 14'(lfsr[RAND_BITS-1:0]);
  assign busy       = (state == S_WAIT) || (state == S_GO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      bright       <= 1'b0;
      presc        <= '0;
      ms_cnt       <= '0;
      target       <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      early        <= 1'b0;
      timeout      <= 1'b0;
`ifdef BEST_TIME_EN
      best_ms      <= 14'h3FFF;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          presc  <= tick ? '0 : presc + 1'b1;
          ms_cnt <= ms_nxt;
          // A press in the same cycle the foreperiod expires is still a
          // false start, so the button is checked first.
          if (btn_rise) begin
            state <= S_EARLY;
            early <= 1'b1;
          end else if (ms_nxt == target) begin
            state  <= S_GO;
            bright <= 1'b1;
            presc  <= '0;   // a full first ms of response time
            ms_cnt <= '0;
          end
        end

        S_GO: begin
          presc  <= tick ? '0 : presc + 1'b1;
          ms_cnt <= ms_nxt;
          // On a press, report the count before any same-cycle increment.
          // A press that ties with the ceiling beats the timeout.
          if (btn_rise) begin
            state        <= S_DONE;
            bright       <= 1'b0;
            result_ms    <= ms_cnt;
            result_valid <= 1'b1;
`ifdef BEST_TIME_EN
            if (ms_cnt < best_ms) best_ms <= ms_cnt;
`endif
          end else if (tick && ms_nxt == MAX_W) begin
            state        <= S_DONE;
            bright       <= 1'b0;
            timeout      <= 1'b1;
            result_ms    <= MAX_W;
            result_valid <= 1'b1;
          end
        end

        default: begin
          // IDLE, DONE and EARLY share the start handling. The timebase is
          // kept parked because it is cleared on entry to WAIT anyway.
          bright <= 1'b0;
          presc  <= '0;
          ms_cnt <= '0;
          if (start) begin
            state   <= S_WAIT;
            target  <= new_target;
            early   <= 1'b0;
            timeout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_seq.sv
module tb_reaction_seq;
  localparam int TICK_DIV    = 4;
  localparam int MIN_WAIT_MS = 2;
  localparam int RAND_BITS   = 2;
  localparam int MAX_MS      = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic        bright, busy, result_valid, early, timeout;
  logic [13:0] result_ms;
`ifdef BEST_TIME_EN
  logic [13:0] best_ms;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reaction_seq #(
    .TICK_DIV(TICK_DIV), .MIN_WAIT_MS(MIN_WAIT_MS),
    .RAND_BITS(RAND_BITS), .MAX_MS(MAX_MS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .bright(bright), .busy(busy), .result_ms(result_ms),
    .result_valid(result_valid), .early(early),
`ifdef BEST_TIME_EN
    .timeout(timeout), .best_ms(best_ms)
`else
    .timeout(timeout)
`endif
  );

  // Reference LFSR (taps 16,14,13,11, seed ACE1). It is used to predict the
  // foreperiod chosen at each start.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int tgt);
    tgt = MIN_WAIT_MS + int'(m_lfsr[1:0]);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_bright(input int limit, output int n);
    n = 0;
    while (!bright && n < limit) begin step(1); n++; end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!result_valid && n < limit) begin step(1); n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 1'b0; start = 1'b0;
    step(2);
    tests++; if (bright !== 1'b0)       begin fails++; $display("FAIL reset_bright: got %b want 0", bright); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (result_ms !== 14'd0)   begin fails++; $display("FAIL reset_result: got %0d want 0", result_ms); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    tests++; if (early !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL reset_flags: got early=%b timeout=%b want 0 0", early, timeout); end
    rst = 1'b0;
  endtask

  // First start right after reset: LFSR=ACE1, so target=3 and bright
  // arrives 12 clocks later. A press placed in GO ms 5 must report 5.
  task automatic test_trial;
    int tgt, n;
    pulse_start(tgt);
    tests++; if (busy !== 1'b1 || bright !== 1'b0) begin fails++; $display("FAIL trial_wait_entry: got busy=%b bright=%b want 1 0", busy, bright); end
    wait_bright(60, n);
    tests++; if (n !== 4 * tgt) begin fails++; $display("FAIL trial_foreperiod: got %0d clks want %0d", n, 4 * tgt); end
    step(4 * 5 - 2);
    btn = 1'b1;
    wait_valid(20, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL trial_btn_latency: got %0d want 4", n); end
    tests++; if (result_ms !== 14'd5) begin fails++; $display("FAIL trial_result: got %0d want 5", result_ms); end
    tests++; if (bright !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL trial_done_outs: got bright=%b busy=%b timeout=%b want 0 0 0", bright, busy, timeout); end
    step(1);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL trial_valid_pulse: got %b want 0", result_valid); end
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_early;
    int tgt, n, seen_bright, seen_valid;
    pulse_start(tgt);
    step(2);
    btn = 1'b1;
    n = 0;
    seen_bright = 0; seen_valid = 0;
    while (!early && n < 20) begin
      step(1); n++;
      if (bright) seen_bright = 1;
      if (result_valid) seen_valid = 1;
    end
    tests++; if (early !== 1'b1 || n !== 4) begin fails++; $display("FAIL early_flag: got early=%b after %0d want 1 after 4", early, n); end
    tests++; if (result_ms !== 14'd5 || busy !== 1'b0) begin fails++; $display("FAIL early_hold: got result=%0d busy=%b want 5 0", result_ms, busy); end
    repeat (30) begin
      step(1);
      if (bright) seen_bright = 1;
      if (result_valid) seen_valid = 1;
    end
    tests++; if (seen_bright != 0 || seen_valid != 0) begin fails++; $display("FAIL early_quiet: got bright_seen=%0d valid_seen=%0d want 0 0", seen_bright, seen_valid); end
    btn = 1'b0;
    step(5);
    pulse_start(tgt);
    tests++; if (early !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL early_clear: got early=%b busy=%b want 0 1", early, busy); end
  endtask

  // Continues the trial started at the end of test_early.
  task automatic test_timeout;
    int n;
    wait_bright(60, n);
    tests++; if (bright !== 1'b1) begin fails++; $display("FAIL timeout_go: got bright=%b want 1", bright); end
    wait_valid(120, n);
    tests++; if (n !== 4 * MAX_MS) begin fails++; $display("FAIL timeout_latency: got %0d clks want %0d", n, 4 * MAX_MS); end
    tests++; if (timeout !== 1'b1 || result_ms !== 14'd20) begin fails++; $display("FAIL timeout_result: got timeout=%b result=%0d want 1 20", timeout, result_ms); end
    tests++; if (bright !== 1'b0 || busy !== 1'b0 || early !== 1'b0) begin fails++; $display("FAIL timeout_outs: got bright=%b busy=%b early=%b want 0 0 0", bright, busy, early); end
    step(1);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL timeout_valid_pulse: got %b want 0", result_valid); end
  endtask

  task automatic test_held_btn;
    int tgt, n, seen_valid;
    btn = 1'b1;
    step(6);
    pulse_start(tgt);
    wait_bright(60, n);
    tests++; if (n !== 4 * tgt || early !== 1'b0) begin fails++; $display("FAIL held_no_early: got clks=%0d early=%b want %0d 0", n, early, 4 * tgt); end
    seen_valid = 0;
    repeat (10) begin step(1); if (result_valid) seen_valid = 1; end
    tests++; if (seen_valid != 0 || busy !== 1'b1) begin fails++; $display("FAIL held_no_response: got valid_seen=%0d busy=%b want 0 1", seen_valid, busy); end
    btn = 1'b0;
    step(4);
    btn = 1'b1;
    wait_valid(20, n);
    tests++; if (result_ms !== 14'd4 || timeout !== 1'b0 || n !== 4) begin fails++; $display("FAIL held_repress: got result=%0d timeout=%b clks=%0d want 4 0 4", result_ms, timeout, n); end
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_start_in_go_and_rst;
    int tgt, n;
    pulse_start(tgt);
    wait_bright(60, n);
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    tests++; if (bright !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL go_start_ignored: got bright=%b busy=%b want 1 1", bright, busy); end
    rst = 1'b1;
    #1;
    tests++; if (bright !== 1'b0 || busy !== 1'b0 || result_ms !== 14'd0 || early !== 1'b0 || timeout !== 1'b0) begin
      fails++; $display("FAIL midgo_reset: got bright=%b busy=%b result=%0d early=%b timeout=%b want 0 0 0 0 0", bright, busy, result_ms, early, timeout);
    end
    step(2);
    rst = 1'b0;
    step(8);
    tests++; if (bright !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got bright=%b busy=%b want 0 0", bright, busy); end
  endtask

`ifdef BEST_TIME_EN
  task automatic press_trial(input int m, output int nb, output int nv);
    int tgt;
    pulse_start(tgt);
    wait_bright(60, nb);
    step(4 * m - 2);
    btn = 1'b1;
    wait_valid(20, nv);
    btn = 1'b0;
    step(5);
  endtask

  task automatic test_best;
    int nb, nv, tgt;
    int ms_list[3] = '{7, 4, 9};
    int best_exp[3] = '{7, 4, 4};
    test_reset;
    tests++; if (best_ms !== 14'h3FFF) begin fails++; $display("FAIL best_reset: got %h want 3fff", best_ms); end
    for (int i = 0; i < 3; i++) begin
      press_trial(ms_list[i], nb, nv);
      tests++; if (result_ms !== 14'(ms_list[i]) || best_ms !== 14'(best_exp[i])) begin
        fails++; $display("FAIL best_trial%0d: got result=%0d best=%0d want %0d %0d", i, result_ms, best_ms, ms_list[i], best_exp[i]);
      end
    end
    pulse_start(tgt);
    wait_bright(60, nb);
    wait_valid(120, nv);
    tests++; if (timeout !== 1'b1 || best_ms !== 14'd4) begin fails++; $display("FAIL best_timeout: got timeout=%b best=%0d want 1 4", timeout, best_ms); end
  endtask
`endif

  initial begin
    test_reset;
    test_trial;
    test_early;
    test_timeout;
    test_held_btn;
    test_start_in_go_and_rst;
`ifdef BEST_TIME_EN
    test_best;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got hang want finish");
    $fatal(1);
  end

endmodule
